// File: rtl/alu_cmp_ctrl_pkg.sv
// Shared opcode/funct constants and control-field encodings for the MIPS
// decode/execute slice; the surrounding pipeline imports this package as well.
package alu_cmp_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;  // bltz
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // A t_use of 3 means the operand is never read by this instruction.
  localparam logic [1:0] T_UNUSED = 2'd3;

  typedef enum logic [1:0] {REG_DST_RT, REG_DST_RD, REG_DST_RA, REG_DST_NONE} reg_dst_e;
  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI} ext_op_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_PASSB
  } alu_op_e;
  typedef enum logic [1:0] {M2R_ALU, M2R_DM, M2R_PC8} mem_to_reg_e;
  typedef enum logic [1:0] {ST_NONE, ST_SW, ST_SH, ST_SB} store_op_e;
  typedef enum logic [2:0] {DEXT_WORD, DEXT_LBU, DEXT_LB, DEXT_LHU, DEXT_LH} dext_op_e;
  typedef enum logic [2:0] {NPC_PC4, NPC_BEQ, NPC_BNE, NPC_BLTZ, NPC_J, NPC_JR} npc_sel_e;

  typedef struct packed {
    reg_dst_e    reg_dst;
    ext_op_e     ext_op;
    logic        alu_src;
    alu_op_e     alu_op;
    logic        reg_write;
    mem_to_reg_e mem_to_reg;
    store_op_e   store_op;
    dext_op_e    dext_op;
    npc_sel_e    npc_sel;
    logic [1:0]  t_use_rs;
    logic [1:0]  t_use_rt;
    logic [1:0]  t_new;
  } ctrl_t;

  // No-op decode: everything zero, both operands unused.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c          = '0;
    c.t_use_rs = T_UNUSED;
    c.t_use_rt = T_UNUSED;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmp_ctrl_decoder.sv
// Combinational main decoder: D-stage opcode/funct to control fields and
// hazard timing (t_use/t_new).
module alu_cmp_ctrl_decoder
  import alu_cmp_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: the full default assignment up front keeps every path assigned,
    // so no latch is inferred for fields an instruction leaves untouched.
    ctrl = ctrl_nop();
    unique case (op)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          ctrl.npc_sel  = NPC_JR;
          ctrl.t_use_rs = 2'd0;
        end else if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU, FN_SLL}) begin
          ctrl.reg_dst   = REG_DST_RD;
          ctrl.reg_write = 1'b1;
          ctrl.t_use_rs  = 2'd1;
          ctrl.t_use_rt  = 2'd1;
          ctrl.t_new     = 2'd1;
          unique case (funct)
            FN_ADD:  ctrl.alu_op = ALU_ADD;
            FN_SUB:  ctrl.alu_op = ALU_SUB;
            FN_AND:  ctrl.alu_op = ALU_AND;
            FN_OR:   ctrl.alu_op = ALU_OR;
            FN_SLT:  ctrl.alu_op = ALU_SLT;
            FN_SLTU: ctrl.alu_op = ALU_SLTU;
            default: begin
              ctrl.alu_op   = ALU_SLL;
              ctrl.t_use_rs = T_UNUSED;
            end
          endcase
        end
      end
      OP_ORI, OP_ANDI, OP_ADDI, OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.t_use_rs  = 2'd1;
        ctrl.t_new     = 2'd1;
        unique case (op)
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ADDI: begin
            ctrl.ext_op = EXT_SIGN;
            ctrl.alu_op = ALU_ADD;
          end
          default: begin
            ctrl.ext_op   = EXT_LUI;
            ctrl.alu_op   = ALU_PASSB;
            ctrl.t_use_rs = T_UNUSED;
          end
        endcase
      end
      OP_LW, OP_LBU, OP_LB, OP_LHU, OP_LH: begin
        ctrl.ext_op     = EXT_SIGN;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_DM;
        ctrl.t_use_rs   = 2'd1;
        ctrl.t_new      = 2'd2;
        unique case (op)
          OP_LBU:  ctrl.dext_op = DEXT_LBU;
          OP_LB:   ctrl.dext_op = DEXT_LB;
          OP_LHU:  ctrl.dext_op = DEXT_LHU;
          OP_LH:   ctrl.dext_op = DEXT_LH;
          default: ctrl.dext_op = DEXT_WORD;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl.ext_op   = EXT_SIGN;
        ctrl.alu_src  = 1'b1;
        ctrl.t_use_rs = 2'd1;
        ctrl.t_use_rt = 2'd2;
        unique case (op)
          OP_SH:   ctrl.store_op = ST_SH;
          OP_SB:   ctrl.store_op = ST_SB;
          default: ctrl.store_op = ST_SW;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        ctrl.ext_op   = EXT_SIGN;
        ctrl.npc_sel  = (op == OP_BEQ) ? NPC_BEQ : NPC_BNE;
        ctrl.t_use_rs = 2'd0;
        ctrl.t_use_rt = 2'd0;
      end
      OP_REGIMM: begin
        ctrl.ext_op   = EXT_SIGN;
        ctrl.npc_sel  = NPC_BLTZ;
        ctrl.t_use_rs = 2'd0;
      end
      OP_J: ctrl.npc_sel = NPC_J;
      OP_JAL: begin
        ctrl.npc_sel    = NPC_J;
        ctrl.reg_dst    = REG_DST_RA;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC8;
      end
      default: ctrl = ctrl_nop();
    endcase
  end

endmodule

// File: rtl/alu_cmp_ctrl.sv
// Decode/execute slice: main decoder, D-stage branch comparator, E-stage ALU
// and the E/M result register.
module alu_cmp_ctrl
  import alu_cmp_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] cmp_a,
  input  logic [31:0] cmp_b,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  ext_op,
  output logic        alu_src,
  output logic [3:0]  alu_op_d,
  output logic        reg_write,
  output logic [1:0]  mem_to_reg,
  output logic [1:0]  store_op,
  output logic [2:0]  dext_op,
  output logic [2:0]  npc_sel,
  output logic [1:0]  t_use_rs,
  output logic [1:0]  t_use_rt,
  output logic [1:0]  t_new,
  output logic        is_same,
  output logic        is_nega,
  output logic [31:0] alu_c,
  output logic [31:0] alu_c_q
);

  ctrl_t ctrl;

  alu_cmp_ctrl_decoder u_decoder (
    .op    (op),
    .funct (funct),
    .ctrl  (ctrl)
  );

  assign reg_dst    = ctrl.reg_dst;
  assign ext_op     = ctrl.ext_op;
  assign alu_src    = ctrl.alu_src;
  assign alu_op_d   = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign store_op   = ctrl.store_op;
  assign dext_op    = ctrl.dext_op;
  assign npc_sel    = ctrl.npc_sel;
  assign t_use_rs   = ctrl.t_use_rs;
  assign t_use_rt   = ctrl.t_use_rt;
  assign t_new      = ctrl.t_new;

  assign is_same = (cmp_a == cmp_b);
  assign is_nega = cmp_a[31];

  always_comb begin
    alu_c = '0;
    case (alu_op)
      ALU_ADD:   alu_c = alu_a + alu_b;
      ALU_SUB:   alu_c = alu_a - alu_b;
      ALU_AND:   alu_c = alu_a & alu_b;
      ALU_OR:    alu_c = alu_a | alu_b;
      ALU_SLT:   alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_c = {31'd0, alu_a < alu_b};
      ALU_SLL:   alu_c = alu_b << shamt;
      ALU_PASSB: alu_c = alu_b;
      default:   alu_c = '0;
    endcase
  end

  // No enable: the surrounding pipeline registers handle stalls.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (reset) alu_c_q <= '0;
    else       alu_c_q <= alu_c;
  end

endmodule

// File: tb/tb_alu_cmp_ctrl.sv
// Scoreboard bench for alu_cmp_ctrl: stimulus queues hand-computed
// expectations, a monitor compares them against the DUT outputs.
module tb_alu_cmp_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = '0, funct = '0;
  logic [31:0] cmp_a = '0, cmp_b = '0, alu_a = '0, alu_b = '0;
  logic [4:0]  shamt = '0;
  logic [3:0]  alu_op = '0;
  logic [1:0]  reg_dst, ext_op, mem_to_reg, store_op, t_use_rs, t_use_rt, t_new;
  logic        alu_src, reg_write, is_same, is_nega;
  logic [3:0]  alu_op_d;
  logic [2:0]  dext_op, npc_sel;
  logic [31:0] alu_c, alu_c_q;

  alu_cmp_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .alu_a(alu_a), .alu_b(alu_b),
    .shamt(shamt), .alu_op(alu_op),
    .reg_dst(reg_dst), .ext_op(ext_op), .alu_src(alu_src), .alu_op_d(alu_op_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .store_op(store_op),
    .dext_op(dext_op), .npc_sel(npc_sel), .t_use_rs(t_use_rs),
    .t_use_rt(t_use_rt), .t_new(t_new), .is_same(is_same), .is_nega(is_nega),
    .alu_c(alu_c), .alu_c_q(alu_c_q)
  );

  always #5 clk = ~clk;

  typedef enum {SEL_CTRL, SEL_CMP, SEL_ALU_C, SEL_ALU_C_Q} sel_e;
  typedef struct {
    sel_e        sel;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   total = 0;
  int   bad = 0;

  // Packed control snapshot in a fixed field order (26 bits).
  function automatic logic [31:0] mk_ctrl(
    input logic [1:0] rd, input logic [1:0] ext, input logic src,
    input logic [3:0] aop, input logic rw, input logic [1:0] m2r,
    input logic [1:0] st, input logic [2:0] dx, input logic [2:0] npc,
    input logic [1:0] urs, input logic [1:0] urt, input logic [1:0] tn);
    return {6'd0, rd, ext, src, aop, rw, m2r, st, dx, npc, urs, urt, tn};
  endfunction

  function automatic logic [31:0] actual(input sel_e s);
    case (s)
      SEL_CTRL:  return {6'd0, reg_dst, ext_op, alu_src, alu_op_d, reg_write,
                         mem_to_reg, store_op, dext_op, npc_sel,
                         t_use_rs, t_use_rt, t_new};
      SEL_CMP:   return {30'd0, is_same, is_nega};
      SEL_ALU_C: return alu_c;
      default:   return alu_c_q;
    endcase
  endfunction

  // Monitor: on each sample strobe drain the scoreboard against live outputs.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() != 0) begin
        exp_t e;
        logic [31:0] act;
        e   = sb.pop_front();
        act = actual(e.sel);
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic check(input sel_e s, input string name, input logic [31:0] exp);
    exp_t e;
    e.sel = s; e.name = name; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    ->sample_ev;
    #1;
  endtask

  task automatic set_alu(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    alu_op = o; alu_a = a; alu_b = b; shamt = sh;
    #1;
  endtask

  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    op = o; funct = f;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check(SEL_ALU_C_Q, "reset_q", 32'h0);
    sample();
    @(negedge clk);
    reset = 1'b0;

    // ALU vectors
    @(negedge clk);
    set_alu(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
    check(SEL_ALU_C, "add_wrap", 32'h8000_0000);
    sample();
    @(posedge clk); #1;
    check(SEL_ALU_C_Q, "add_wrap_q", 32'h8000_0000);
    sample();

    @(negedge clk);
    set_alu(4'd1, 32'd5, 32'd7, 5'd0);
    check(SEL_ALU_C, "sub", 32'hFFFF_FFFE); sample();
    set_alu(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    check(SEL_ALU_C, "and", 32'h0000_F000); sample();
    set_alu(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd0);
    check(SEL_ALU_C, "or", 32'h0000_FFF0); sample();
    set_alu(4'd4, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check(SEL_ALU_C, "slt_neg", 32'h1); sample();
    set_alu(4'd5, 32'hFFFF_FFFF, 32'h1, 5'd0);
    check(SEL_ALU_C, "sltu_big", 32'h0); sample();
    set_alu(4'd5, 32'h1, 32'hFFFF_FFFF, 5'd0);
    check(SEL_ALU_C, "sltu_small", 32'h1); sample();
    set_alu(4'd6, 32'h0, 32'h1, 5'd31);
    check(SEL_ALU_C, "sll31", 32'h8000_0000); sample();
    set_alu(4'd7, 32'h1234_5678, 32'hCAFE_0000, 5'd3);
    check(SEL_ALU_C, "passb", 32'hCAFE_0000); sample();
    set_alu(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    check(SEL_ALU_C, "alu15", 32'h0); sample();

    // Comparator
    cmp_a = 32'h1234; cmp_b = 32'h1234; #1;
    check(SEL_CMP, "cmp_same", 32'h2); sample();
    cmp_a = 32'h8000_0000; cmp_b = 32'h1234; #1;
    check(SEL_CMP, "cmp_nega", 32'h1); sample();

    // Decoder: rd ext src aop rw m2r st dx npc urs urt tn
    set_instr(6'b100011, 6'b000000);
    check(SEL_CTRL, "lw", mk_ctrl(0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 3, 2)); sample();
    set_instr(6'b100001, 6'b111111);
    check(SEL_CTRL, "lh", mk_ctrl(0, 1, 1, 0, 1, 1, 0, 4, 0, 1, 3, 2)); sample();
    set_instr(6'b000011, 6'b000000);
    check(SEL_CTRL, "jal", mk_ctrl(2, 0, 0, 0, 1, 2, 0, 0, 4, 3, 3, 0)); sample();
    set_instr(6'b000000, 6'b001000);
    check(SEL_CTRL, "jr", mk_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 3, 0)); sample();
    set_instr(6'b000000, 6'b000000);
    check(SEL_CTRL, "nop_sll", mk_ctrl(1, 0, 0, 6, 1, 0, 0, 0, 0, 3, 1, 1)); sample();
    set_instr(6'b000000, 6'b101010);
    check(SEL_CTRL, "slt", mk_ctrl(1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 1, 1)); sample();
    set_instr(6'b001111, 6'b000000);
    check(SEL_CTRL, "lui", mk_ctrl(0, 2, 1, 7, 1, 0, 0, 0, 0, 3, 3, 1)); sample();
    set_instr(6'b001101, 6'b000000);
    check(SEL_CTRL, "ori", mk_ctrl(0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 1)); sample();
    set_instr(6'b101000, 6'b000000);
    check(SEL_CTRL, "sb", mk_ctrl(0, 1, 1, 0, 0, 0, 3, 0, 0, 1, 2, 0)); sample();
    set_instr(6'b000101, 6'b000000);
    check(SEL_CTRL, "bne", mk_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0)); sample();
    set_instr(6'b000001, 6'b000000);
    check(SEL_CTRL, "bltz", mk_ctrl(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 3, 0)); sample();
    set_instr(6'b000010, 6'b000000);
    check(SEL_CTRL, "j", mk_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 3, 0)); sample();
    set_instr(6'b000000, 6'b111111);
    check(SEL_CTRL, "bad_funct", mk_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0)); sample();

    // Undefined opcode: every output zero except t_use fields
    cmp_a = 32'h1; cmp_b = 32'h2;
    set_alu(4'd8, 32'h5, 32'h6, 5'd0);
    set_instr(6'b111111, 6'b000000);
    check(SEL_CTRL, "undef_ctrl", mk_ctrl(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0));
    check(SEL_CMP, "undef_cmp", 32'h0);
    check(SEL_ALU_C, "undef_alu", 32'h0);
    sample();

    // Mid-cycle asynchronous reset
    @(negedge clk);
    set_alu(4'd7, 32'h0, 32'hDEAD_BEEF, 5'd0);
    @(posedge clk); #1;
    check(SEL_ALU_C_Q, "q_deadbeef", 32'hDEAD_BEEF); sample();
    #1 reset = 1'b1;
    #1;
    check(SEL_ALU_C_Q, "async_reset", 32'h0); sample();
    @(posedge clk); #1;
    check(SEL_ALU_C_Q, "reset_hold", 32'h0); sample();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check(SEL_ALU_C_Q, "resume", 32'hDEAD_BEEF); sample();

    // Bounded drain of anything left in the scoreboard
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      ->sample_ev;
      #1;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
